// File: rtl/picorv_mem_arbiter.sv
// Two-requester arbiter for a picorv-style native memory port.
// M0 is the core, M1 is the stream/DMA loader. A grant is held for one whole transaction.
// There is always at least one idle cycle between transactions, so the memory block
// always sees mem_valid fall. The stream strobes in that block need the rising edge.
// A sticky watchdog flags a slave that stalls a granted transfer for too long.
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   m{0,1}_valid/addr/wdata/wstrb       requester inputs (wstrb 0 = read)
//   m{0,1}_ready                        transfer-complete pulse to the owner only
//   m{0,1}_rdata                        shared read data, qualified by mX_ready
//   s_mem_valid/addr/wdata/wstrb        muxed request to the memory block
//   s_mem_ready, s_mem_rdata            memory completion and read data
//   grant                               one-hot current owner (00 = idle)
//   timeout_err                         sticky watchdog flag
module picorv_mem_arbiter #(
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_mem_valid,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

  state_e           state_q;
  logic [1:0]       grant_q;
  logic             last_q;      // 1 = M1 owned the last completed transfer
  logic [CNT_W-1:0] wd_cnt_q;
  logic             timeout_q;
  logic             pick_m0;

  // On a tie, M0 wins under fixed priority, or when M1 had the last completed transfer.
  assign pick_m0 = (FIXED_PRIO != 0) || last_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_valid && (!m1_valid || pick_m0)) begin
            state_q  <= StOwn0;
            grant_q  <= 2'b01;
            wd_cnt_q <= '0;
          end else if (m1_valid) begin
            state_q  <= StOwn1;
            grant_q  <= 2'b10;
            wd_cnt_q <= '0;
          end
        end
        StOwn0: begin
          if (s_mem_ready) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= 1'b0;
          end else if (!m0_valid) begin
            // The requester abandoned the transfer. It does not count as a completed turn.
            state_q <= StIdle;
            grant_q <= 2'b00;
          end
        end
        StOwn1: begin
          if (s_mem_ready) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
          end else if (!m1_valid) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase

      // Count stalled owner cycles and saturate. The transfer itself is never aborted.
      if ((state_q != StIdle) && !s_mem_ready && (wd_cnt_q != CntMax)) begin
        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      end

      if ((TIMEOUT_CYCLES != 0) && (wd_cnt_q == TimeoutVal)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign grant       = grant_q;
  assign timeout_err = timeout_q;
  assign m0_rdata    = s_mem_rdata;
  assign m1_rdata    = s_mem_rdata;

  always_comb begin
    s_mem_valid = 1'b0;
    s_mem_addr  = 32'h0;
    s_mem_wdata = 32'h0;
    s_mem_wstrb = 4'h0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    unique case (state_q)
      StOwn0: begin
        s_mem_valid = m0_valid;
        s_mem_addr  = m0_addr;
        s_mem_wdata = m0_wdata;
        s_mem_wstrb = m0_wstrb;
        m0_ready    = s_mem_ready;
      end
      StOwn1: begin
        s_mem_valid = m1_valid;
        s_mem_addr  = m1_addr;
        s_mem_wdata = m1_wdata;
        s_mem_wstrb = m1_wstrb;
        m1_ready    = s_mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// Self-checking bench for picorv_mem_arbiter. There are two instances:
//   u_dut : round-robin, TIMEOUT_CYCLES=16; main scoreboard-driven tests
//   u_fp  : fixed priority, both masters held valid; M1 must starve
module tb_picorv_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_mem_valid, s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  // Fixed-priority instance signals
  logic        fp_m0_valid, fp_m1_valid, fp_m0_ready, fp_m1_ready;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_s_valid, fp_s_ready;
  logic [31:0] fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_wstrb;
  logic [1:0]  fp_grant;
  logic        fp_timeout;

  always #5 clk = ~clk;

  picorv_mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(16), .CNT_W(5)) u_dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata),
    .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  picorv_mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(16), .CNT_W(5)) u_fp (
    .clk(clk), .resetn(resetn),
    .m0_valid(fp_m0_valid), .m0_addr(32'h0000_0200), .m0_wdata(32'h0), .m0_wstrb(4'h0),
    .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_valid(fp_m1_valid), .m1_addr(32'h0000_0300), .m1_wdata(32'h0), .m1_wstrb(4'h0),
    .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .s_mem_valid(fp_s_valid), .s_mem_addr(fp_s_addr), .s_mem_wdata(fp_s_wdata),
    .s_mem_wstrb(fp_s_wstrb), .s_mem_ready(fp_s_ready), .s_mem_rdata(32'h0000_5555),
    .grant(fp_grant), .timeout_err(fp_timeout)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  typedef struct {
    bit          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  function automatic void push_exp(input bit id, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] ws);
    exp_t e;
    e.id = id; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = mem_word(a);
    sb.push_back(e);
  endfunction

  // Memory model: ready fires mem_delay cycles after it first sees valid.
  int mem_delay = 2;
  initial begin
    int cnt = 0;
    s_mem_ready = 1'b0;
    s_mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (s_mem_valid && !s_mem_ready) begin
        cnt++;
        if (cnt >= mem_delay) begin
          s_mem_ready = 1'b1;
          s_mem_rdata = mem_word(s_mem_addr);
          cnt = 0;
        end
      end else begin
        s_mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Fixed-priority memory model: zero wait states.
  initial begin
    fp_s_ready  = 1'b0;
    fp_m0_valid = 1'b1;
    fp_m1_valid = 1'b1;
    forever begin
      @(posedge clk); #1;
      fp_s_ready = fp_s_valid && !fp_s_ready;
    end
  end

  int fp_m1_hits = 0;
  int fp_m0_done = 0;
  initial forever begin
    @(negedge clk);
    if (fp_grant == 2'b10 || fp_m1_ready) fp_m1_hits++;
    if (fp_m0_ready) fp_m0_done++;
  end

  // Completion monitor: pops the scoreboard and checks the following bubble cycle.
  initial begin
    bit idle_chk = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        check("bubble_grant", {30'h0, grant}, 32'h0);
        check("ready_pulse", {30'h0, m1_ready, m0_ready}, 32'h0);
        idle_chk = 0;
      end else if (resetn && (m0_ready || m1_ready)) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check("rdy_owner", {30'h0, m1_ready, m0_ready}, e.id ? 32'h2 : 32'h1);
          check("grant", {30'h0, grant}, e.id ? 32'h2 : 32'h1);
          check("s_addr", s_mem_addr, e.addr);
          check("s_wdata", s_mem_wdata, e.wdata);
          check("s_wstrb", {28'h0, s_mem_wstrb}, {28'h0, e.wstrb});
          check("rdata", e.id ? m1_rdata : m0_rdata, e.rdata);
        end
        idle_chk = 1;
      end
    end
  end

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws);
    if (!id) begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
    end
  endtask

  task automatic wait_done(input bit id);
    int n = 0;
    bit got = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      got = id ? m1_ready : m0_ready;
    end
    if (!got) check(id ? "m1_done_timeout" : "m0_done_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (!id) m0_valid = 1'b0;
    else     m1_valid = 1'b0;
  endtask

  task automatic do_xfer(input bit id, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
    drive(id, a, wd, ws);
    wait_done(id);
  endtask

  task automatic wait_grant(input logic [1:0] g, input string tag);
    int n = 0;
    while (grant !== g && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'h0, grant}, {30'h0, g});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stuck");
  end

  initial begin
    resetn   = 1'b0;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;

    // Reset state
    #23;
    check("rst_valid", {31'h0, s_mem_valid}, 32'h0);
    check("rst_grant", {30'h0, grant}, 32'h0);
    check("rst_ready", {30'h0, m1_ready, m0_ready}, 32'h0);
    check("rst_timeout", {31'h0, timeout_err}, 32'h0);
    check("rst_addr", s_mem_addr, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // M0-only read with a one-cycle request-to-valid latency
    @(posedge clk); #1;
    push_exp(0, 32'h10, 32'h0, 4'h0);
    drive(0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("lat_idle_valid", {31'h0, s_mem_valid}, 32'h0);
    @(negedge clk);
    check("lat_valid", {31'h0, s_mem_valid}, 32'h1);
    check("lat_grant", {30'h0, grant}, 32'h1);
    check("lat_addr", s_mem_addr, 32'h10);
    wait_done(0);

    // Round robin: both masters valid at reset exit, grants must alternate
    @(negedge clk);
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 32'h100 + 32'(i * 4), 32'h1122_3344, 4'hF);
      push_exp(1, 32'h20, 32'h0, 4'h0);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) do_xfer(0, 32'h100 + 32'(i * 4), 32'h1122_3344, 4'hF);
      end
      begin
        for (int i = 0; i < 4; i++) do_xfer(1, 32'h20, 32'h0, 4'h0);
      end
      begin
        repeat (2) @(negedge clk);
        resetn = 1'b1;
      end
    join
    repeat (2) @(negedge clk);

    // Stream stall: watchdog fires but the transfer still completes
    mem_delay = 30;
    push_exp(0, 32'h1000_0004, 32'h0, 4'h0);
    drive(0, 32'h1000_0004, 32'h0, 4'h0);
    wait_grant(2'b01, "wd_grant");
    repeat (13) @(negedge clk);
    check("wd_early", {31'h0, timeout_err}, 32'h0);
    repeat (6) @(negedge clk);
    check("wd_fired", {31'h0, timeout_err}, 32'h1);
    wait_done(0);
    repeat (3) @(negedge clk);
    check("wd_sticky", {31'h0, timeout_err}, 32'h1);

    // M1 abandons its request: last_grant stays M0, so the next tie goes to M1
    mem_delay = 100;
    drive(1, 32'h40, 32'h0, 4'h0);
    wait_grant(2'b10, "drop_grant");
    @(posedge clk); #1;
    m1_valid = 1'b0;
    @(negedge clk);
    check("drop_valid", {31'h0, s_mem_valid}, 32'h0);
    @(negedge clk);
    check("drop_idle", {30'h0, grant}, 32'h0);
    check("drop_no_ready", {31'h0, m1_ready}, 32'h0);
    mem_delay = 2;
    push_exp(1, 32'h44, 32'h0, 4'h0);
    push_exp(0, 32'h48, 32'hCAFE_F00D, 4'h3);
    fork
      do_xfer(1, 32'h44, 32'h0, 4'h0);
      do_xfer(0, 32'h48, 32'hCAFE_F00D, 4'h3);
    join
    repeat (2) @(negedge clk);

    // Reset while M1 owns the bus
    mem_delay = 100;
    push_exp(1, 32'h30, 32'h0, 4'h0);
    drive(1, 32'h30, 32'h0, 4'h0);
    wait_grant(2'b10, "mid_grant");
    @(negedge clk);
    check("mid_valid_pre", {31'h0, s_mem_valid}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, s_mem_valid}, 32'h0);
    check("mid_rst_grant", {30'h0, grant}, 32'h0);
    check("mid_rst_ready", {31'h0, m1_ready}, 32'h0);
    check("mid_rst_timeout", {31'h0, timeout_err}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    mem_delay = 2;
    @(negedge clk);
    check("regrant", {30'h0, grant}, 32'h2);
    check("regrant_valid", {31'h0, s_mem_valid}, 32'h1);
    wait_done(1);
    repeat (3) @(negedge clk);

    // Wrap-up
    check("sb_left", 32'(sb.size()), 32'h0);
    check("fp_m1_starved", 32'(fp_m1_hits), 32'h0);
    check("fp_m0_served", {31'h0, fp_m0_done > 10}, 32'h1);
    check("fp_no_timeout", {31'h0, fp_timeout}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
